// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter in front of one memory port.
//
// Master 0 (CPU) and master 1 (loader/DMA) share the memory port. A grant
// from IDLE is issued in the same cycle as the request. A write completes in
// that single cycle. A read keeps ownership of the port until the read data
// returns or the read times out.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   mN_ren_i / mN_wen_i      master N read / write request (wen wins if both)
//   mN_addr_i, mN_wdata_i    master N byte address, write data
//   mN_wr_mask_i             master N byte-lane write mask
//   mN_gnt_o                 master N request accepted this cycle
//   mN_rdata_o/_rd_valid_o   master N read return (rdata is 0 when not valid)
//   mem_*_o                  memory strobes, address, write data, byte mask
//   mem_rdata_i/_rd_valid_i  memory read return
//   err_o                    sticky read-timeout flag
module mem_arbiter #(
  parameter int W       = 32,
  parameter int AW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_ren_i,
  input  logic          m0_wen_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [W-1:0]  m0_wdata_i,
  input  logic [3:0]    m0_wr_mask_i,
  output logic          m0_gnt_o,
  output logic [W-1:0]  m0_rdata_o,
  output logic          m0_rd_valid_o,
  input  logic          m1_ren_i,
  input  logic          m1_wen_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [W-1:0]  m1_wdata_i,
  input  logic [3:0]    m1_wr_mask_i,
  output logic          m1_gnt_o,
  output logic [W-1:0]  m1_rdata_o,
  output logic          m1_rd_valid_o,
  output logic          mem_ren_o,
  output logic          mem_wen_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [W-1:0]  mem_wdata_o,
  output logic [3:0]    mem_wr_mask_o,
  input  logic [W-1:0]  mem_rdata_i,
  input  logic          mem_rd_valid_i,
  output logic          err_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, RD_WAIT} state_e;

  typedef struct packed {
    logic          ren;
    logic          wen;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [3:0]    mask;
  } req_t;

  req_t [1:0]         req;
  logic [1:0]         want;
  logic               win;
  logic [1:0]         gnt;
  logic [1:0]         rd_vld;
  logic [W-1:0]       rd_data;
  logic [1:0][W-1:0]  rdata_m;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic           err_q, err_d;
  logic [AW-1:0]  addr_q, addr_d;

  assign req[0] = {m0_ren_i, m0_wen_i, m0_addr_i, m0_wdata_i, m0_wr_mask_i};
  assign req[1] = {m1_ren_i, m1_wen_i, m1_addr_i, m1_wdata_i, m1_wr_mask_i};

  for (genvar i = 0; i < 2; i++) begin : g_m
    assign want[i]    = req[i].ren | req[i].wen;
    // Non-owners and idle cycles see zero read data.
    assign rdata_m[i] = rd_vld[i] ? rd_data : '0;
  end

  // Master 1 wins when it is the only requester, or on a tie when master 0
  // was served last.
  assign win = want[1] & ~(want[0] & last_q);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    tmo_cnt_d     = tmo_cnt_q;
    err_d         = err_q;
    addr_d        = addr_q;
    gnt           = '0;
    rd_vld        = '0;
    rd_data       = '0;
    mem_ren_o     = 1'b0;
    mem_wen_o     = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    mem_wr_mask_o = 4'hF;
    case (state_q)
      IDLE: begin
        if (|want) begin
          gnt[win]   = 1'b1;
          last_d     = win;
          mem_addr_o = req[win].addr;
          if (req[win].wen) begin
            mem_wen_o     = 1'b1;
            mem_wdata_o   = req[win].wdata;
            mem_wr_mask_o = req[win].mask;
          end else begin
            mem_ren_o = 1'b1;
            owner_d   = win;
            addr_d    = req[win].addr;
            tmo_cnt_d = '0;
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // Address comes from the registered copy: the master may drop its
        // request once granted.
        mem_ren_o  = 1'b1;
        mem_addr_o = addr_q;
        if (mem_rd_valid_i) begin
          rd_vld[owner_q] = 1'b1;
          rd_data         = mem_rdata_i;
          state_d         = IDLE;
        end else if (TIMEOUT != 0 && tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          // Close the read with zero data so the owner is not left hanging.
          rd_vld[owner_q] = 1'b1;
          err_d           = 1'b1;
          state_d         = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
    end
  end

  assign m0_gnt_o      = gnt[0];
  assign m1_gnt_o      = gnt[1];
  assign m0_rd_valid_o = rd_vld[0];
  assign m1_rd_valid_o = rd_vld[1];
  assign m0_rdata_o    = rdata_m[0];
  assign m1_rdata_o    = rdata_m[1];
  assign err_o         = err_q;

endmodule
